// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: multi-cycle binary-to-BCD converter (shift-and-add-3,
// one input bit per clock) with start/busy/done handshake, sticky overflow
// and optional leading-zero blank mask.
// Optional feature macro: BCD_BLANK_EN (enables the registered digit_blank mask).
module bcd_seq_converter #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      score_bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     digit_blank
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic [BIN_W-1:0]      shift_reg;
    logic [BCD_W-1:0]      scratch;
    logic                  sticky;

    logic [BCD_W-1:0]      corrected;
    logic [BCD_W-1:0]      scratch_shifted;
    logic                  carry_out;
    logic                  accept;
    logic                  last_shift;

    // Add 3 to every digit that is 5 or more; digits are corrected independently.
    function automatic logic [BCD_W-1:0] add3_correct(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5)
                res[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
        return res;
    endfunction

`ifdef BCD_BLANK_EN
    // Digit k (k>=1) is blanked when it and every digit above it are zero.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] bcd);
        logic [DIGITS-1:0] mask;
        logic              zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (bcd[4*k +: 4] == 4'd0);
            mask[k]    = zero_above;
        end
        return mask;
    endfunction
`endif

    // One shift step: correct, shift left, pull in the next input bit.
    always_comb begin
        corrected       = add3_correct(scratch);
        scratch_shifted = {corrected[BCD_W-2:0], shift_reg[BIN_W-1]};
        carry_out       = corrected[BCD_W-1];
        accept          = (state == IDLE) && start;
        last_shift      = (state == SHIFT) && (cnt == LAST_CNT);
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == LAST_CNT) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (state == SHIFT);
    end

    // Bit counter and sticky overflow, cleared on accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (state == SHIFT) begin
            cnt    <= cnt + CNT_W'(1);
            sticky <= sticky | carry_out;
        end
    end

    // Datapath shift registers; contents are don't-care until an accept loads them.
    always_ff @(posedge clock) begin
        if (accept) begin
            shift_reg <= score_bin;
            scratch   <= '0;
        end else if (state == SHIFT) begin
            shift_reg <= shift_reg << 1;
            scratch   <= scratch_shifted;
        end
    end

    // Result commit on the final shift, with a one-cycle done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done      <= 1'b0;
            score_bcd <= '0;
            overflow  <= 1'b0;
        end else begin
            done <= last_shift;
            if (last_shift) begin
                score_bcd <= scratch_shifted;
                overflow  <= sticky | carry_out;
            end
        end
    end

`ifdef BCD_BLANK_EN
    // Blank mask registered alongside the committed result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            digit_blank <= {{(DIGITS-1){1'b1}}, 1'b0};
        else if (last_shift)
            digit_blank <= blank_mask(scratch_shifted);
    end
`else
    assign digit_blank = '0;
`endif

endmodule
